// File: rtl/lp_printer_responder.sv
// Printer-side Centronics responder: synchronizes host strobe, captures a byte, runs BUSY/ACK, queues bytes in a FIFO.
// Latency: strobe fall at pin -> LPBUSY in 3 clk; capture -> LPACKn low after BUSY_CYCLES+1 clk, low for ACK_CYCLES clk.
// Backpressure: a full FIFO holds LPBUSY high in WAIT until the consumer pops. Optional macro: LP_STROBE_FILTER_EN.
module lp_printer_responder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int BUSY_CYCLES = 64,
  parameter int ACK_CYCLES  = 32,
  parameter int STB_MIN     = 4
) (
  input  logic                          clk,
  input  logic                          RESETBn,
  input  logic                          LPSTBn,
  input  logic [7:0]                    LPDATA,
  output logic                          LPBUSY,
  output logic                          LPACKn,
  output logic                          LPERRn,
  output logic                          LPON,
  input  logic                          online,
  input  logic                          err_clr,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int TMAX = (BUSY_CYCLES > ACK_CYCLES) ? BUSY_CYCLES : ACK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  // Reject parameter sets the datapath cannot honour
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      BUSY_CYCLES < 1 || ACK_CYCLES < 1 || STB_MIN < 1) begin : g_bad_param
    $error("lp_printer_responder: illegal parameter value");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [7:0]      hold_q, hold_d;
  logic            busy_q, busy_d;
  logic            ackn_q, ackn_d;
  logic            errn_q, errn_d;
  logic            lpon_q;
  logic            stb_s0_q, stb_s1_q;
  logic            stb_evt;
  logic            push, pop, fifo_full, ovf_set;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CNTW-1:0] cnt_q;

  // Two-flop synchronizer for the asynchronous host strobe; idles high
  always_ff @(posedge clk or negedge RESETBn) begin
    if (!RESETBn) begin
      stb_s0_q <= 1'b1;
      stb_s1_q <= 1'b1;
    end else begin
      stb_s0_q <= LPSTBn;
      stb_s1_q <= stb_s0_q;
    end
  end

`ifdef LP_STROBE_FILTER_EN
  localparam int LW = $clog2(STB_MIN + 1);
  logic [LW-1:0] low_cnt_q;

  // Count consecutive synchronized-low cycles, saturating so a long strobe is accepted once
  always_ff @(posedge clk or negedge RESETBn) begin
    if (!RESETBn) begin
      low_cnt_q <= '0;
    end else if (stb_s1_q) begin
      low_cnt_q <= '0;
    end else if (low_cnt_q != LW'(STB_MIN)) begin
      low_cnt_q <= low_cnt_q + LW'(1);
    end
  end

  // Accept on the STB_MIN-th consecutive low cycle; shorter pulses never get here
  assign stb_evt = !stb_s1_q && (low_cnt_q == LW'(STB_MIN - 1));
`else
  logic stb_prev_q;

  // Previous synchronized level, for falling-edge detection
  always_ff @(posedge clk or negedge RESETBn) begin
    if (!RESETBn) stb_prev_q <= 1'b1;
    else          stb_prev_q <= stb_s1_q;
  end

  assign stb_evt = !stb_s1_q && stb_prev_q;
`endif

  assign fifo_full = (cnt_q == CNTW'(FIFO_DEPTH));
  assign pop       = out_ready && (cnt_q != '0);

  // Handshake FSM: next state, timer, hold register and pin levels
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    ackn_d  = ackn_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stb_evt && lpon_q) begin
          hold_d  = LPDATA;
          busy_d  = 1'b1;
          tmr_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tmr_q == TW'(BUSY_CYCLES)) begin
          // A pop in the same cycle frees the slot we push into
          if (!fifo_full || pop) begin
            push    = 1'b1;
            ackn_d  = 1'b0;
            tmr_d   = '0;
            state_d = S_ACK;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_ACK: begin
        if (tmr_q == TW'(ACK_CYCLES - 1)) begin
          ackn_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_RELEASE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_RELEASE: begin
        if (stb_s1_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A strobe while a byte is still in flight is lost; flag it sticky until cleared
  assign ovf_set = stb_evt && ((state_q == S_WAIT) || (state_q == S_ACK));

  // Overflow flag: a new overflow wins over a simultaneous clear
  always_comb begin
    errn_d = errn_q;
    if (ovf_set)      errn_d = 1'b0;
    else if (err_clr) errn_d = 1'b1;
  end

  // FSM and host-facing pin registers
  always_ff @(posedge clk or negedge RESETBn) begin
    if (!RESETBn) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      ackn_q  <= 1'b1;
      errn_q  <= 1'b1;
      lpon_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      ackn_q  <= ackn_d;
      errn_q  <= errn_d;
      lpon_q  <= online;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge RESETBn) begin
    if (!RESETBn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are meaningless while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= hold_q;
  end

  assign LPBUSY    = busy_q;
  assign LPACKn    = ackn_q;
  assign LPERRn    = errn_q;
  assign LPON      = lpon_q;
  assign out_data  = mem_q[rptr_q];
  assign out_valid = (cnt_q != '0);
  assign fifo_cnt  = cnt_q;

endmodule
